// File: rtl/fg_cfg_pkg.sv
// Shared constants, commit-FSM encoding and register map for the function generator config bank.
package fg_cfg_pkg;

    localparam int unsigned DEF_NUM_REGS    = 8;
    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_ADDR_W      = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    // Commit FSM encoding
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    // Register indices consumed by the waveform core
    localparam int unsigned REG_WAVE_SEL = 0;
    localparam int unsigned REG_FREQ_HI  = 1;
    localparam int unsigned REG_FREQ_LO  = 2;
    localparam int unsigned REG_AMPL     = 3;
    localparam int unsigned REG_OFFSET   = 4;
    localparam int unsigned REG_DUTY     = 5;
    localparam int unsigned REG_PHASE    = 6;
    localparam int unsigned REG_CTRL     = 7;

    typedef enum logic [1:0] {
        DEC_REG    = 2'd0,
        DEC_COMMIT = 2'd1,
        DEC_ERR    = 2'd2
    } dec_e;

    // The commit request register sits just past the last data register
    function automatic int unsigned commit_addr(input int unsigned num_regs);
        return num_regs;
    endfunction

endpackage

// File: rtl/fg_config_bank_if.sv
// Host write bus plus waveform-core side signals of the config bank.
interface fg_config_bank_if
    import fg_cfg_pkg::*;
#(
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W
);
    logic                         wr_en_async_i;
    logic [ADDR_W-1:0]            addr_i;
    logic [DATA_W-1:0]            data_i;
    logic                         frame_sync_i;
    logic [NUM_REGS*DATA_W-1:0]   cfg_bus_o;
    logic                         pending_o;
    logic                         commit_done_o;
    logic                         wr_ack_o;
    logic                         addr_err_o;

    modport master (
        output wr_en_async_i, addr_i, data_i, frame_sync_i,
        input  cfg_bus_o, pending_o, commit_done_o, wr_ack_o, addr_err_o
    );

    modport slave (
        input  wr_en_async_i, addr_i, data_i, frame_sync_i,
        output cfg_bus_o, pending_o, commit_done_o, wr_ack_o, addr_err_o
    );
endinterface

// File: rtl/fg_sync_edge.sv
// N-stage synchroniser for an asynchronous strobe with a single-cycle rising-edge event output.
module fg_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic evt_c_o
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign evt_c_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/fg_config_bank.sv
// Shadow/active configuration register bank with a frame-aligned atomic commit.
module fg_config_bank
    import fg_cfg_pkg::*;
#(
    parameter int unsigned      NUM_REGS    = DEF_NUM_REGS,
    parameter int unsigned      DATA_W      = DEF_DATA_W,
    parameter int unsigned      ADDR_W      = DEF_ADDR_W,
    parameter int unsigned      SYNC_STAGES = DEF_SYNC_STAGES,
    parameter bit               AUTO_COMMIT = 1'b0,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    fg_config_bank_if.slave bus
);
    localparam int unsigned COMMIT_ADDR = commit_addr(NUM_REGS);

    logic              wr_evt_c;
    dec_e              dec_c;
    logic              reg_wr_c;
    logic              commit_wr_c;
    logic              copy_c;
    logic [NUM_REGS*DATA_W-1:0] cfg_flat_c;

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] shadow_q [NUM_REGS];
    logic [DATA_W-1:0] shadow_d [NUM_REGS];
    logic [DATA_W-1:0] active_q [NUM_REGS];
    logic [DATA_W-1:0] active_d [NUM_REGS];
    logic              wr_ack_q, wr_ack_d;
    logic              addr_err_q, addr_err_d;
    logic              commit_done_q, commit_done_d;

    fg_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (bus.wr_en_async_i),
        .evt_c_o (wr_evt_c)
    );

    // Address class; addr/data are quasi-static so sampling them unsynchronised is safe
    always_comb begin
        dec_c = DEC_ERR;
        if (bus.addr_i < ADDR_W'(NUM_REGS)) begin
            dec_c = DEC_REG;
        end else if (bus.addr_i == ADDR_W'(COMMIT_ADDR)) begin
            dec_c = DEC_COMMIT;
        end
    end

    assign reg_wr_c    = wr_evt_c && (dec_c == DEC_REG);
    assign commit_wr_c = wr_evt_c && (dec_c == DEC_COMMIT);

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        copy_c        = 1'b0;
        wr_ack_d      = reg_wr_c || commit_wr_c;
        addr_err_d    = wr_evt_c && (dec_c == DEC_ERR);

        if (!AUTO_COMMIT) begin
            case (state_q)
                ST_IDLE: begin
                    if (commit_wr_c && bus.data_i[0]) begin
                        state_d = ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    // A cancel on the same edge as frame_sync wins: nothing is copied
                    if (commit_wr_c && !bus.data_i[0]) begin
                        state_d = ST_IDLE;
                    end else if (bus.frame_sync_i) begin
                        state_d = ST_IDLE;
                        copy_c  = 1'b1;
                    end
                end
            endcase
        end

        // Copy reads the pre-write shadow, so a colliding write stays shadow-only
        if (copy_c) begin
            active_d = shadow_q;
        end

        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (reg_wr_c && (bus.addr_i == ADDR_W'(i))) begin
                shadow_d[i] = bus.data_i;
                if (AUTO_COMMIT) begin
                    active_d[i] = bus.data_i;
                end
            end
        end

        commit_done_d = copy_c;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            wr_ack_q      <= 1'b0;
            addr_err_q    <= 1'b0;
            commit_done_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= RESET_VALUE;
                active_q[i] <= RESET_VALUE;
            end
        end else begin
            state_q       <= state_d;
            wr_ack_q      <= wr_ack_d;
            addr_err_q    <= addr_err_d;
            commit_done_q <= commit_done_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
        end
    end

    // Register 0 occupies the most significant byte lane
    always_comb begin
        cfg_flat_c = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            cfg_flat_c[(NUM_REGS-1-i)*DATA_W +: DATA_W] = active_q[i];
        end
    end

    assign bus.cfg_bus_o     = cfg_flat_c;
    assign bus.pending_o     = AUTO_COMMIT ? 1'b0 : state_q[0];
    assign bus.commit_done_o = AUTO_COMMIT ? 1'b0 : commit_done_q;
    assign bus.wr_ack_o      = wr_ack_q;
    assign bus.addr_err_o    = addr_err_q;

endmodule

// File: tb/tb_fg_config_bank.sv
// Scoreboard bench for fg_config_bank: commit-protocol instance (dut0) and auto-commit instance (dut1).
module tb_fg_config_bank;
    localparam int SYNC = 2;

    typedef struct {
        logic [2:0]  kind;   // {wr_ack, addr_err, commit_done}
        logic [63:0] cfg;
        logic        pend;
        int          cyc;
    } exp_t;

    localparam logic [2:0] K_ACK  = 3'b100;
    localparam logic [2:0] K_ERR  = 3'b010;
    localparam logic [2:0] K_DONE = 3'b001;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q0[$];
    exp_t q1[$];

    fg_config_bank_if #(.NUM_REGS(8), .DATA_W(8), .ADDR_W(4)) if0 ();
    fg_config_bank_if #(.NUM_REGS(8), .DATA_W(8), .ADDR_W(4)) if1 ();

    fg_config_bank #(.SYNC_STAGES(SYNC), .AUTO_COMMIT(1'b0)) u_dut0 (
        .clk_i (clk), .rst_i (rst0), .bus (if0)
    );
    fg_config_bank #(.SYNC_STAGES(SYNC), .AUTO_COMMIT(1'b1)) u_dut1 (
        .clk_i (clk), .rst_i (rst1), .bus (if1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_pulse(input int d, input logic [2:0] kind, input logic [63:0] cfg,
                               input logic pend);
        exp_t e;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL dut%0d_unexpected_pulse actual=%b required=none cyc=%0d", d, kind, cyc);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("dut%0d_pulse_kind", d), 64'(kind), 64'(e.kind));
        chk($sformatf("dut%0d_pulse_cycle", d), 64'(cyc), 64'(e.cyc));
        chk($sformatf("dut%0d_cfg_bus", d), cfg, e.cfg);
        chk($sformatf("dut%0d_pending", d), 64'(pend), 64'(e.pend));
    endtask

    // Monitor: every output pulse must match the oldest expectation for that instance
    always @(negedge clk) begin
        if (if0.wr_ack_o || if0.addr_err_o || if0.commit_done_o)
            check_pulse(0, {if0.wr_ack_o, if0.addr_err_o, if0.commit_done_o},
                        if0.cfg_bus_o, if0.pending_o);
        if (if1.wr_ack_o || if1.addr_err_o || if1.commit_done_o)
            check_pulse(1, {if1.wr_ack_o, if1.addr_err_o, if1.commit_done_o},
                        if1.cfg_bus_o, if1.pending_o);
    end

    task automatic set_bus(input int d, input logic s, input logic [3:0] a, input logic [7:0] dat);
        if (d == 0) begin if0.wr_en_async_i = s; if0.addr_i = a; if0.data_i = dat; end
        else        begin if1.wr_en_async_i = s; if1.addr_i = a; if1.data_i = dat; end
    endtask

    task automatic set_fs(input int d, input logic v);
        if (d == 0) if0.frame_sync_i = v;
        else        if1.frame_sync_i = v;
    endtask

    // Strobe rises after edge c0, write lands on edge c0+SYNC+1; with_fs aligns frame_sync to that edge
    task automatic host_write(input int d, input logic [3:0] a, input logic [7:0] dat,
                              input int hold, input bit with_fs, input logic [2:0] kind,
                              input logic [63:0] cfg, input logic pend);
        exp_t e;
        @(posedge clk); #1;
        set_bus(d, 1'b1, a, dat);
        e.kind = kind; e.cfg = cfg; e.pend = pend; e.cyc = cyc + SYNC + 1;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        for (int k = 1; k <= hold + SYNC + 3; k++) begin
            @(posedge clk); #1;
            set_fs(d, with_fs && (k == SYNC));
            if (k == hold) set_bus(d, 1'b0, a, dat);
        end
    endtask

    task automatic frame(input int d, input bit expect_done, input logic [63:0] cfg);
        exp_t e;
        @(posedge clk); #1;
        if (expect_done) begin
            e.kind = K_DONE; e.cfg = cfg; e.pend = 1'b0; e.cyc = cyc + 1;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        set_fs(d, 1'b1);
        @(posedge clk); #1;
        set_fs(d, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] cfg_a, cfg_b, cfg_c;
        cfg_a = 64'h0000A50000000000;
        cfg_b = 64'h0000A51100000000;
        cfg_c = 64'h3C00A51100000000;
        set_bus(0, 1'b0, 4'd0, 8'd0); set_bus(1, 1'b0, 4'd0, 8'd0);
        set_fs(0, 1'b0); set_fs(1, 1'b0);

        repeat (2) @(negedge clk);
        chk("reset_cfg0", if0.cfg_bus_o, 64'h0);
        chk("reset_flags0", 64'({if0.pending_o, if0.commit_done_o, if0.wr_ack_o, if0.addr_err_o}), 64'h0);
        chk("reset_cfg1", if1.cfg_bus_o, 64'h0);
        @(posedge clk); #1;
        rst0 = 1'b0; rst1 = 1'b0;

        // Plain shadow write leaves the active bus untouched
        host_write(0, 4'd2, 8'hA5, 4, 1'b0, K_ACK, 64'h0, 1'b0);
        chk("idle_pending", 64'(if0.pending_o), 64'h0);

        // Commit request, then frame_sync applies it
        host_write(0, 4'd8, 8'h01, 4, 1'b0, K_ACK, 64'h0, 1'b1);
        repeat (10) @(posedge clk);
        #1 chk("pending_held", 64'(if0.pending_o), 64'h1);
        frame(0, 1'b1, cfg_a);
        repeat (2) @(posedge clk);
        #1 chk("reg2_lane", 64'(if0.cfg_bus_o[47:40]), 64'hA5);
        chk("pending_cleared", 64'(if0.pending_o), 64'h0);

        // Long strobe writes once; illegal address only flags an error
        host_write(0, 4'd3, 8'h11, 50, 1'b0, K_ACK, cfg_a, 1'b0);
        host_write(0, 4'd9, 8'hFF, 4, 1'b0, K_ERR, cfg_a, 1'b0);

        // Write colliding with the commit edge stays in shadow
        host_write(0, 4'd8, 8'h01, 4, 1'b0, K_ACK, cfg_a, 1'b1);
        host_write(0, 4'd0, 8'h3C, 4, 1'b1, K_ACK | K_DONE, cfg_b, 1'b0);
        host_write(0, 4'd8, 8'h01, 4, 1'b0, K_ACK, cfg_b, 1'b1);
        frame(0, 1'b1, cfg_c);

        // Request on the same edge as frame_sync waits for the next one
        host_write(0, 4'd8, 8'h01, 4, 1'b1, K_ACK, cfg_c, 1'b1);
        frame(0, 1'b1, cfg_c);

        // Cancel: no copy, no commit_done
        host_write(0, 4'd8, 8'h01, 4, 1'b0, K_ACK, cfg_c, 1'b1);
        host_write(0, 4'd1, 8'h99, 4, 1'b0, K_ACK, cfg_c, 1'b1);
        host_write(0, 4'd8, 8'h00, 4, 1'b0, K_ACK, cfg_c, 1'b0);
        frame(0, 1'b0, 64'h0);
        repeat (3) @(posedge clk);
        #1 chk("cancel_cfg", if0.cfg_bus_o, cfg_c);
        chk("cancel_pending", 64'(if0.pending_o), 64'h0);

        // Auto-commit instance: active follows the write edge, commit writes are no-ops
        host_write(1, 4'd7, 8'h7F, 4, 1'b0, K_ACK, 64'h7F, 1'b0);
        host_write(1, 4'd8, 8'h01, 4, 1'b0, K_ACK, 64'h7F, 1'b0);
        frame(1, 1'b0, 64'h0);
        repeat (3) @(posedge clk);
        #1 chk("auto_reg7", 64'(if1.cfg_bus_o[7:0]), 64'h7F);
        chk("auto_pending", 64'(if1.pending_o), 64'h0);

        // Mid-write reset on the auto-commit instance
        @(posedge clk); #1;
        set_bus(1, 1'b1, 4'd2, 8'h55);
        @(posedge clk); #2 rst1 = 1'b1;
        #1 chk("auto_rst_cfg", if1.cfg_bus_o, 64'h0);
        chk("auto_rst_flags", 64'({if1.wr_ack_o, if1.addr_err_o}), 64'h0);
        set_bus(1, 1'b0, 4'd2, 8'h55);
        repeat (5) @(posedge clk);
        #1 rst1 = 1'b0;
        repeat (8) @(posedge clk);
        #1 chk("auto_after_rst", if1.cfg_bus_o, 64'h0);

        // Reset while a commit is pending discards it
        host_write(0, 4'd8, 8'h01, 4, 1'b0, K_ACK, cfg_c, 1'b1);
        @(posedge clk); #2 rst0 = 1'b1;
        #1 chk("rst_pending", 64'(if0.pending_o), 64'h0);
        chk("rst_cfg", if0.cfg_bus_o, 64'h0);
        @(posedge clk); #1 rst0 = 1'b0;
        frame(0, 1'b0, 64'h0);
        repeat (3) @(posedge clk);
        #1 chk("post_rst_cfg", if0.cfg_bus_o, 64'h0);
        chk("post_rst_pending", 64'(if0.pending_o), 64'h0);

        for (int k = 0; k < 20 && (q0.size() + q1.size()) > 0; k++) @(posedge clk);
        chk("q0_drained", 64'(q0.size()), 64'h0);
        chk("q1_drained", 64'(q1.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fg_config_bank.md
Name: fg_config_bank

Overview:
Parametrised configuration register bank for the function generator, replacing the flat 8x8-bit register file in the top level. It takes a pad-level asynchronous write strobe, synchronises it and detects its rising edge, so each host strobe writes exactly once. Writes land in shadow registers, and the waveform core sees a separate active copy. Shadow-to-active transfer is either immediate or an atomic commit aligned to a waveform frame boundary, so the output never sees a half-updated configuration.

Parameters:
NUM_REGS, 8, number of configuration registers (2..15)
DATA_W, 8, register width in bits
ADDR_W, 4, address width; must satisfy 2**ADDR_W > NUM_REGS
SYNC_STAGES, 2, flip-flop stages in the write-strobe synchroniser (>=2)
AUTO_COMMIT, 0, 1 = every write updates shadow and active on the same edge; 0 = commit protocol
RESET_VALUE, 0, reset value of every shadow and active register

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; asynchronous, active-high
wr_en_async_i  in  1  host write strobe, asynchronous to clk_i
addr_i  in  ADDR_W  register address; quasi-static
data_i  in  DATA_W  write data; quasi-static
frame_sync_i  in  1  one-cycle pulse from the waveform core at a period boundary
cfg_bus_o  out  NUM_REGS*DATA_W  active registers; reg 0 in the MSBs
pending_o  out  1  commit requested, not yet applied
commit_done_o  out  1  one-cycle pulse when shadow is copied to active
wr_ack_o  out  1  one-cycle pulse after each accepted write or commit-address write
addr_err_o  out  1  one-cycle pulse on a write to an illegal address

Behaviour:
- Reset (async assert; deassert is synchronous to clk_i): shadow = active = RESET_VALUE, synchroniser and edge flop = 0, pending_o = 0, and all pulse outputs = 0.
- Synchroniser: wr_en_async_i passes through SYNC_STAGES flops. An edge flop holds the previous synchronised value. A write event is synced=1 and prev=0.
- Latency: if the strobe rises with setup before clock edge 1, the write executes at edge SYNC_STAGES+1. wr_ack_o / addr_err_o are high for the cycle after that edge.
- A held-high strobe produces exactly one write. The strobe must be low for at least SYNC_STAGES+1 cycles between writes.
- Host requirement: addr_i and data_i must be stable from before the strobe rises until after it falls. They are sampled unsynchronised on the write edge.
- Address decode at the write event:
  - addr < NUM_REGS: write shadow[addr]; pulse wr_ack_o.
  - addr == NUM_REGS (COMMIT_ADDR): pulse wr_ack_o. data_i[0]=1 sets the pending request; data_i[0]=0 clears it. The other data bits are ignored.
  - addr > NUM_REGS: no state change; pulse addr_err_o only.
- Commit FSM (AUTO_COMMIT=0), states IDLE and PENDING:
  - IDLE -> PENDING on a commit write with data_i[0]=1.
  - PENDING -> IDLE on a commit write with data_i[0]=0 (cancel; no copy, no commit_done_o).
  - PENDING -> IDLE on frame_sync_i=1: active <= shadow on that edge; commit_done_o pulses the next cycle.
  - frame_sync_i in IDLE: no effect.
  - pending_o is 1 exactly in PENDING.
- Simultaneous events:
  - Request and frame_sync_i on the same edge: the request is registered, and the copy waits for the next frame_sync_i.
  - Shadow write and frame_sync_i on the same edge while PENDING: active takes the pre-write shadow value; the new value stays in shadow.
  - Shadow writes during PENDING are legal; the latest values are committed.
- AUTO_COMMIT=1: a register write updates shadow and active on the same edge. Commit writes are acked no-ops. pending_o and commit_done_o are tied to 0.
- Mid-operation reset: all state returns to reset values immediately, and any pending commit is discarded.
- cfg_bus_o is driven directly from the active flops; there is no combinational path from inputs.

Decomposition:
- Shared package fg_cfg_pkg holds:
  - default constants (NUM_REGS, DATA_W, ADDR_W, SYNC_STAGES);
  - the COMMIT_ADDR definition (= NUM_REGS);
  - the commit state encoding (IDLE=0, PENDING=1);
  - the register-index constants used by the waveform core.
- One sub-module, fg_sync_edge: an N-stage synchroniser plus rising-edge detector with active-high async reset, output is the single-cycle write event. The remainder (decode, shadow/active arrays, FSM) stays in fg_config_bank.

Test Plan:
1. Defaults, AUTO_COMMIT=0: write 0xA5 to addr 2 -> wr_ack_o pulses 4 cycles after the strobe rises. Shadow[2]=0xA5, and cfg_bus_o is unchanged (all zero).
2. Then write 0x01 to addr 8, pulse frame_sync_i 10 cycles later -> pending_o=1 until that edge. cfg_bus_o[47:40]=0xA5 afterwards, commit_done_o pulses once, pending_o=0.
3. Hold the strobe high for 50 cycles on addr 3, data 0x11 -> exactly one wr_ack_o. Write to addr 9 -> addr_err_o pulses once and no register changes.
4. While PENDING, write 0x3C to addr 0 on the same edge as frame_sync_i -> active reg 0 keeps its old value, shadow[0]=0x3C. A second request plus frame_sync_i commits 0x3C.
5. Request a commit, then write 0x00 to addr 8 -> pending_o=0. A later frame_sync_i produces no copy and no commit_done_o.
6. AUTO_COMMIT=1: write 0x7F to addr 7 -> cfg_bus_o[7:0]=0x7F on the write edge. Assert rst_i mid-sequence -> all outputs return to 0 asynchronously.
